// File: rtl/adc_sample_packer_pkg.sv
// Shared types and widths for the ADC sample packer.
// Four 32-bit lane slots make up one 128-bit memory word.
package adc_sample_packer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } state_t;

  localparam int LANES_PER_WORD = 4;
  localparam int LANE_W         = 16;
  localparam int WORD_W         = 128;
  localparam int SLOT_W         = 2 * LANE_W;

  // Channel B occupies the upper half of a slot.
  function automatic logic [SLOT_W-1:0] pack_slot(
    input logic [LANE_W-1:0] a,
    input logic [LANE_W-1:0] b
  );
    return {b, a};
  endfunction

endpackage

// File: rtl/adc_word_assembler.sv
// Gathers four sample pairs into one 128-bit word.
// Flags a full word one cycle later.
module adc_word_assembler
  import adc_sample_packer_pkg::*;
#(
  parameter int ADC_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic [ADC_W-1:0]  a_i,
  input  logic [ADC_W-1:0]  b_i,
  output logic [WORD_W-1:0] word_o,
  output logic              full_o
);

  localparam logic [1:0] LAST_LANE = 2'(LANES_PER_WORD - 1);

  logic [1:0]                               lane_q;
  logic [LANES_PER_WORD-2:0][SLOT_W-1:0]    slot_q;
  logic [WORD_W-1:0]                        hold_q;
  logic                                     full_q;
  logic [SLOT_W-1:0]                        pair;
  logic                                     last;

  assign pair = pack_slot(LANE_W'(a_i), LANE_W'(b_i));
  assign last = push_i && (lane_q == LAST_LANE);

  // A completing pair wins over clear so abort cannot lose a full word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q <= '0;
      slot_q <= '0;
      hold_q <= '0;
      full_q <= 1'b0;
    end else begin
      full_q <= last;
      if (last) begin
        hold_q <= {pair, slot_q};
        lane_q <= '0;
      end else if (clear_i) begin
        lane_q <= '0;
      end else if (push_i) begin
        slot_q[lane_q] <= pair;
        lane_q         <= lane_q + 2'd1;
      end
    end
  end

  assign word_o = hold_q;
  assign full_o = full_q;

endmodule

// File: rtl/adc_sample_packer.sv
// Capture FSM, write address and memory-port drive
// for packing ADC sample pairs into 128-bit words.
module adc_sample_packer
  import adc_sample_packer_pkg::*;
#(
  parameter int ADC_W  = 12,
  parameter int DEPTH  = 18750,
  parameter int ADDR_W = 15,
  parameter int WRAP   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              sample_valid,
  input  logic [ADC_W-1:0]  adc_a_data,
  input  logic [ADC_W-1:0]  adc_b_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic [127:0]      mem_writedata,
  output logic [15:0]       mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_clken,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_written
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   MAX_WORDS = (ADDR_W + 1)'(DEPTH);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   words_q;
  logic              busy_q;
  logic              done_q;

  logic              in_cap;
  logic              arm;
  logic              wr;
  logic              at_last;
  logic              stop;
  logic              clear;
  logic              push;
  logic [WORD_W-1:0] word;

  assign in_cap  = (state_q == CAPTURE);
  assign arm     = start && !in_cap;
  assign at_last = (addr_q == LAST_ADDR);
  assign stop    = in_cap && (abort || (wr && at_last && WRAP == 0));
  assign clear   = arm || (in_cap && abort);
  assign push    = sample_valid && in_cap;

  adc_word_assembler #(
    .ADC_W (ADC_W)
  ) u_asm (
    .clk     (clk),
    .reset   (reset),
    .clear_i (clear),
    .push_i  (push),
    .a_i     (adc_a_data),
    .b_i     (adc_b_data),
    .word_o  (word),
    .full_o  (wr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      words_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // A write pending when abort hits still lands and is counted.
      if (wr) begin
        if (!at_last)
          addr_q <= addr_q + 1'b1;
        else if (WRAP != 0)
          addr_q <= '0;
        if (words_q != MAX_WORDS)
          words_q <= words_q + 1'b1;
      end
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= CAPTURE;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            addr_q  <= '0;
            words_q <= '0;
          end
        end
        CAPTURE: begin
          if (stop) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_address    = addr_q;
  assign mem_writedata  = word;
  assign mem_byteenable = '1;
  assign mem_chipselect = wr;
  assign mem_write      = wr;
  assign mem_clken      = 1'b1;
  assign busy           = busy_q;
  assign done           = done_q;
  assign words_written  = words_q;

endmodule

// File: tb/tb_adc_sample_packer.sv
// Scoreboard bench: a stop-when-full and a wrapping packer,
// both DEPTH=4, fed the same sample stream.
module tb_adc_sample_packer;
  import adc_sample_packer_pkg::*;

  localparam int D = 4;

  typedef struct {
    logic [14:0]  addr;
    logic [127:0] data;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic sv = 1'b0;
  logic [11:0] a = '0;
  logic [11:0] b = '0;

  logic [1:0]         mw, cs, cken, busy, done;
  logic [1:0][14:0]   ma;
  logic [1:0][127:0]  md;
  logic [1:0][15:0]   be, ww;

  exp_t         sq [2][$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  logic [127:0] last_data [2];
  logic [14:0]  last_addr [2];
  exp_t         mon_e;

  int           lane [2];
  int           addr [2];
  int           words [2];
  bit           cap [2];
  bit           dn [2];
  logic [127:0] acc [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_sample_packer #(
    .ADC_W(12), .DEPTH(D), .ADDR_W(15), .WRAP(0)
  ) u0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .sample_valid(sv), .adc_a_data(a), .adc_b_data(b),
    .mem_address(ma[0]), .mem_writedata(md[0]),
    .mem_byteenable(be[0]), .mem_chipselect(cs[0]),
    .mem_write(mw[0]), .mem_clken(cken[0]),
    .busy(busy[0]), .done(done[0]), .words_written(ww[0])
  );

  adc_sample_packer #(
    .ADC_W(12), .DEPTH(D), .ADDR_W(15), .WRAP(1)
  ) u1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .sample_valid(sv), .adc_a_data(a), .adc_b_data(b),
    .mem_address(ma[1]), .mem_writedata(md[1]),
    .mem_byteenable(be[1]), .mem_chipselect(cs[1]),
    .mem_write(mw[1]), .mem_clken(cken[1]),
    .busy(busy[1]), .done(done[1]), .words_written(ww[1])
  );

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (mw[m] === 1'b1) begin
        n_cmp++;
        if (sq[m].size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write dut%0d got addr=%0h data=%h want none",
                   m, ma[m], md[m]);
        end else begin
          mon_e = sq[m].pop_front();
          if (ma[m] !== mon_e.addr || md[m] !== mon_e.data ||
              cyc != mon_e.cyc || cs[m] !== 1'b1) begin
            n_err++;
            $display("FAIL write dut%0d got a=%0h d=%h cyc=%0d cs=%b want a=%0h d=%h cyc=%0d cs=1",
                     m, ma[m], md[m], cyc, cs[m],
                     mon_e.addr, mon_e.data, mon_e.cyc);
          end
        end
        last_data[m] = md[m];
        last_addr[m] = ma[m];
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 0; abort = 0; sv = 0;
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1; abort = 0; sv = 0;
    for (int m = 0; m < 2; m++) begin
      if (!cap[m]) begin
        cap[m] = 1; dn[m] = 0; lane[m] = 0;
        addr[m] = 0; words[m] = 0;
      end
    end
  endtask

  task automatic do_abort();
    @(negedge clk);
    start = 0; abort = 1; sv = 0;
    for (int m = 0; m < 2; m++) begin
      if (cap[m]) begin
        cap[m] = 0; dn[m] = 1; lane[m] = 0;
      end
    end
  endtask

  task automatic send_pair(input logic [11:0] va, input logic [11:0] vb,
                           input bit ab);
    exp_t e;
    @(negedge clk);
    start = 0; abort = ab; sv = 1; a = va; b = vb;
    for (int m = 0; m < 2; m++) begin
      if (cap[m]) begin
        acc[m][lane[m]*32 +: 32] = {4'h0, vb, 4'h0, va};
        if (lane[m] == 3) begin
          e.addr = 15'(addr[m]);
          e.data = acc[m];
          e.cyc  = cyc + 1;
          sq[m].push_back(e);
          lane[m] = 0;
          if (words[m] < D) words[m]++;
          if (addr[m] == D - 1) begin
            if (m == 1) addr[m] = 0;
            else begin cap[m] = 0; dn[m] = 1; end
          end else begin
            addr[m]++;
          end
        end else begin
          lane[m]++;
        end
        if (ab) begin cap[m] = 0; dn[m] = 1; lane[m] = 0; end
      end
    end
  endtask

  task automatic test_reset();
    idle(2);
    for (int m = 0; m < 2; m++) begin
      n_cmp++;
      if ({mw[m], cs[m], busy[m], done[m]} !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_flags dut%0d got %b want 0000",
                 m, {mw[m], cs[m], busy[m], done[m]});
      end
      n_cmp++;
      if (ma[m] !== '0 || md[m] !== '0 || ww[m] !== '0) begin
        n_err++;
        $display("FAIL reset_regs dut%0d got a=%0h d=%h w=%0d want 0",
                 m, ma[m], md[m], ww[m]);
      end
      n_cmp++;
      if (be[m] !== 16'hffff || cken[m] !== 1'b1) begin
        n_err++;
        $display("FAIL reset_const dut%0d got be=%h ck=%b want ffff 1",
                 m, be[m], cken[m]);
      end
    end
    reset = 0;
    idle(2);
  endtask

  task automatic test_single();
    do_start();
    for (int i = 1; i <= 4; i++)
      send_pair(12'(i), 12'(16'h100 + i), 0);
    idle(3);
    for (int m = 0; m < 2; m++) begin
      n_cmp++;
      if (last_data[m] !== 128'h0104_0004_0103_0003_0102_0002_0101_0001 ||
          last_addr[m] !== 15'd0 || sq[m].size() != 0) begin
        n_err++;
        $display("FAIL single_word dut%0d got a=%0h d=%h left=%0d want a=0 d=0104_0004_0103_0003_0102_0002_0101_0001 left=0",
                 m, last_addr[m], last_data[m], sq[m].size());
      end
      n_cmp++;
      if (ww[m] !== 16'd1 || busy[m] !== 1'b1 || done[m] !== 1'b0) begin
        n_err++;
        $display("FAIL single_status dut%0d got w=%0d b=%b d=%b want 1 1 0",
                 m, ww[m], busy[m], done[m]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_abort();
    idle(1);
    do_start();
    for (int i = 0; i < 8; i++)
      send_pair(12'($urandom), 12'($urandom), 0);
    idle(3);
    for (int m = 0; m < 2; m++) begin
      n_cmp++;
      if (ww[m] !== 16'd2 || last_addr[m] !== 15'd1 || sq[m].size() != 0) begin
        n_err++;
        $display("FAIL b2b dut%0d got w=%0d a=%0h left=%0d want 2 1 0",
                 m, ww[m], last_addr[m], sq[m].size());
      end
    end
  endtask

  task automatic test_stop_when_full();
    do_abort();
    do_start();
    for (int i = 0; i < 16; i++)
      send_pair(12'($urandom), 12'($urandom), 0);
    idle(3);
    n_cmp++;
    if (done[0] !== 1'b1 || busy[0] !== 1'b0 || ww[0] !== 16'd4 ||
        last_addr[0] !== 15'd3 || sq[0].size() != 0) begin
      n_err++;
      $display("FAIL full_stop got d=%b b=%b w=%0d a=%0h left=%0d want 1 0 4 3 0",
               done[0], busy[0], ww[0], last_addr[0], sq[0].size());
    end
    n_cmp++;
    if (busy[1] !== 1'b1 || ww[1] !== 16'd4 || sq[1].size() != 0) begin
      n_err++;
      $display("FAIL full_wrapdut got b=%b w=%0d left=%0d want 1 4 0",
               busy[1], ww[1], sq[1].size());
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++)
      send_pair(12'($urandom), 12'($urandom), 0);
    idle(3);
    n_cmp++;
    if (last_addr[1] !== 15'd0 || ww[1] !== 16'd4 || busy[1] !== 1'b1 ||
        done[1] !== 1'b0 || sq[1].size() != 0) begin
      n_err++;
      $display("FAIL wrap got a=%0h w=%0d b=%b d=%b left=%0d want 0 4 1 0 0",
               last_addr[1], ww[1], busy[1], done[1], sq[1].size());
    end
    n_cmp++;
    if (done[0] !== 1'b1 || ww[0] !== 16'd4 || last_addr[0] !== 15'd3) begin
      n_err++;
      $display("FAIL wrap_stopdut got d=%b w=%0d a=%0h want 1 4 3",
               done[0], ww[0], last_addr[0]);
    end
  endtask

  task automatic test_abort();
    do_abort();
    do_start();
    for (int i = 1; i <= 3; i++)
      send_pair(12'(16'h0f0 + i), 12'(16'h0e0 + i), 0);
    do_abort();
    idle(3);
    for (int m = 0; m < 2; m++) begin
      n_cmp++;
      if (done[m] !== 1'b1 || busy[m] !== 1'b0 || ww[m] !== 16'd0 ||
          sq[m].size() != 0) begin
        n_err++;
        $display("FAIL abort_partial dut%0d got d=%b b=%b w=%0d left=%0d want 1 0 0 0",
                 m, done[m], busy[m], ww[m], sq[m].size());
      end
    end
    do_start();
    for (int i = 1; i <= 4; i++)
      send_pair(12'(16'h200 + i), 12'(16'h300 + i), 0);
    idle(3);
    for (int m = 0; m < 2; m++) begin
      n_cmp++;
      if (last_data[m] !== 128'h0304_0204_0303_0203_0302_0202_0301_0201 ||
          last_addr[m] !== 15'd0 || ww[m] !== 16'd1 || sq[m].size() != 0) begin
        n_err++;
        $display("FAIL abort_restart dut%0d got a=%0h d=%h w=%0d want a=0 d=0304_0204_0303_0203_0302_0202_0301_0201 w=1",
                 m, last_addr[m], last_data[m], ww[m]);
      end
    end
  endtask

  task automatic test_abort_same_cycle();
    do_abort();
    do_start();
    for (int i = 0; i < 3; i++)
      send_pair(12'($urandom), 12'($urandom), 0);
    send_pair(12'hfff, 12'h800, 1);
    idle(3);
    for (int m = 0; m < 2; m++) begin
      n_cmp++;
      if (done[m] !== dn[m] || busy[m] !== cap[m] ||
          ww[m] !== 16'(words[m]) || sq[m].size() != 0) begin
        n_err++;
        $display("FAIL abort_commit dut%0d got d=%b b=%b w=%0d left=%0d want %b %b %0d 0",
                 m, done[m], busy[m], ww[m], sq[m].size(),
                 dn[m], cap[m], words[m]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_start();
    for (int i = 0; i < 4; i++)
      send_pair(12'($urandom), 12'($urandom), 0);
    @(posedge clk);
    #1 reset = 1;
    sv = 0;
    #1;
    for (int m = 0; m < 2; m++) begin
      n_cmp++;
      if ({mw[m], cs[m], busy[m], done[m]} !== 4'b0000 ||
          ma[m] !== '0 || md[m] !== '0 || ww[m] !== '0 ||
          be[m] !== 16'hffff || cken[m] !== 1'b1) begin
        n_err++;
        $display("FAIL reset_mid dut%0d got f=%b a=%0h d=%h w=%0d be=%h ck=%b want 0000 0 0 0 ffff 1",
                 m, {mw[m], cs[m], busy[m], done[m]}, ma[m], md[m],
                 ww[m], be[m], cken[m]);
      end
      sq[m].delete();
      cap[m] = 0; dn[m] = 0; lane[m] = 0; addr[m] = 0; words[m] = 0;
    end
    @(negedge clk);
    reset = 0;
    idle(3);
    for (int m = 0; m < 2; m++) begin
      n_cmp++;
      if (busy[m] !== 1'b0 || done[m] !== 1'b0 || ww[m] !== 16'd0) begin
        n_err++;
        $display("FAIL reset_release dut%0d got b=%b d=%b w=%0d want 0 0 0",
                 m, busy[m], done[m], ww[m]);
      end
    end
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      cap[m] = 0; dn[m] = 0; lane[m] = 0; addr[m] = 0; words[m] = 0;
      acc[m] = '0; last_data[m] = '0; last_addr[m] = '0;
    end
    test_reset();
    test_single();
    test_back_to_back();
    test_stop_when_full();
    test_wrap();
    test_abort();
    test_abort_same_cycle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adc_sample_packer.md
ADC_SAMPLE_PACKER -- requirements
Module: adc_sample_packer

Interface
REQ-001 Parameter ADC_W, default 12, width of each ADC sample.
REQ-002 Parameter DEPTH, default 18750, number of 128-bit words in the downstream on-chip memory.
REQ-003 Parameter ADDR_W, default 15, memory word-address width.
REQ-004 Parameter WRAP, default 0; 1 = circular capture, 0 = stop when memory is full.
REQ-005 clk  in  1  single system clock; all logic is rising-edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse that arms a capture.
REQ-008 abort  in  1  one-cycle pulse that ends a capture immediately.
REQ-009 sample_valid  in  1  qualifies adc_a_data and adc_b_data for one cycle.
REQ-010 adc_a_data  in  ADC_W  channel A sample.
REQ-011 adc_b_data  in  ADC_W  channel B sample.
REQ-012 mem_address  out  ADDR_W  word address to the memory.
REQ-013 mem_writedata  out  128  packed word.
REQ-014 mem_byteenable  out  16  byte enables.
REQ-015 mem_chipselect  out  1  memory select.
REQ-016 mem_write  out  1  write strobe.
REQ-017 mem_clken  out  1  memory clock enable.
REQ-018 busy  out  1  capture in progress.
REQ-019 done  out  1  capture finished; held until the next start.
REQ-020 words_written  out  ADDR_W+1  count of words committed in the current capture, saturating at DEPTH.

Function
REQ-021 States: IDLE, CAPTURE, DONE. IDLE->CAPTURE on start. CAPTURE->DONE on abort, or when word DEPTH-1 is written and WRAP=0. DONE->CAPTURE on start.
REQ-022 start in CAPTURE is ignored; abort in IDLE or DONE is ignored.
REQ-023 Entering CAPTURE clears the lane counter, mem_address, words_written and done.
REQ-024 In CAPTURE, each sample_valid stores one sample pair into lane slot k (0..3).
REQ-025 Slot k layout: bits [32k+15:32k] = zero-extended A; bits [32k+31:32k+16] = zero-extended B.
REQ-026 sample_valid outside CAPTURE is discarded.
REQ-027 On the 4th pair, the full word moves into a holding register and the lane counter returns to 0 in the same cycle. A 5th pair arriving in the next cycle is captured into slot 0 without loss.
REQ-028 mem_write and mem_chipselect assert for exactly one cycle, the cycle after the 4th pair, with mem_writedata = holding register and mem_address = current write address. Latency from 4th sample_valid to write strobe is 1 cycle.
REQ-029 mem_byteenable is constant all-ones; mem_clken is constant 1.
REQ-030 The write address increments after each write. At DEPTH-1: with WRAP=1 it returns to 0; with WRAP=0 the FSM enters DONE.
REQ-031 words_written increments per write and saturates at DEPTH.
REQ-032 abort discards any partial word (slots 0..2 filled); a write already pending from the previous cycle still completes.
REQ-033 abort and the 4th sample_valid in the same cycle: the word is committed, then DONE.
REQ-034 busy = 1 only in CAPTURE; done = 1 only in DONE.
REQ-035 Writes never occur outside the strobe cycle; no waitrequest is used, because the memory accepts a write every cycle.

Reset
REQ-036 Asynchronous reset forces: FSM IDLE; mem_write, mem_chipselect, busy, done = 0; mem_address, mem_writedata, words_written, lane counter = 0.
REQ-037 Reset mid-capture drops any pending write, with no strobe on the cycle after release; mem_byteenable and mem_clken remain constant.

Structure
REQ-038 A shared package holds the state enum, LANES_PER_WORD = 4, LANE_W = 16 and WORD_W = 128.
REQ-039 One sub-module, adc_word_assembler, holds the lane counter, slot registers and holding register. The top level holds the FSM, address counter and memory-port drive.

Verification
REQ-040 start, then 4 pairs A=0x001..0x004 and B=0x101..0x104 -> one write at address 0 with word 0x0104_0004_0103_0003_0102_0002_0101_0001, 1 cycle after the 4th valid.
REQ-041 8 back-to-back valid pairs -> writes at addresses 0 and 1 on consecutive strobes, no sample lost, words_written = 2.
REQ-042 WRAP=0, DEPTH=4, 16 pairs -> 4 writes, done = 1 after the write to address 3; further valids produce no writes.
REQ-043 WRAP=1, DEPTH=4, 20 pairs -> 5th write lands at address 0, words_written saturates at 4, busy stays 1.
REQ-044 3 pairs, then abort -> no write, done = 1; restart plus 4 pairs -> write at address 0 with the new data only.
REQ-045 reset asserted in the cycle after the 4th pair -> no mem_write, all outputs at reset values asynchronously.
